// File: rtl/data_ram.sv
// Data-memory responder: byte-lane-masked single-port word RAM behind the load/store memory port.
// Latency: ack_o in the cycle (accept edge + WAIT_CYCLES + 1); one request in flight at a time.
// Backpressure: requester holds mem_ce_i until ack_o; busy_o marks accept..ack, mem_ce_i ignored outside IDLE.
module data_ram #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int         DEPTH   = 1 << ADDR_W;
  // Counter is 4 bits wide: the supported wait range is 0..15.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic        req_we_q;
  logic [31:0] req_addr_q;
  logic [3:0]  req_sel_q;
  logic [31:0] req_data_q;

  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // FSM decode strobes
  logic accept;
  logic enter_resp;

  // Request as seen by the access logic. With zero wait states the access
  // happens on the accept edge itself, before the request registers hold it,
  // so in IDLE the live bus is used instead of the captured copy.
  logic              src_we;
  logic [31:0]       src_addr;
  logic [3:0]        src_sel;
  logic [31:0]       src_data;
  logic              src_err;
  logic [ADDR_W-1:0] src_idx;
  logic [31:0]       lane_mask;
  logic [31:0]       rd_word;
  logic              mem_wr_en;

  logic [31:0] mem_q [DEPTH];

  // State and request registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      req_we_q   <= 1'b0;
      req_addr_q <= 32'd0;
      req_sel_q  <= 4'd0;
      req_data_q <= 32'd0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_we_q   <= mem_we_i;
        req_addr_q <= mem_addr_i;
        req_sel_q  <= mem_sel_i;
        req_data_q <= mem_data_i;
      end
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          accept = 1'b1;
          if (WAIT_LD == 4'd0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        // mem_ce_i deliberately not sampled here; a held request restarts from IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: ack/err only in RESP, busy for every non-IDLE cycle.
  always_comb begin
    ack_o      = (state_q == ST_RESP);
    err_o      = (state_q == ST_RESP) && err_q;
    busy_o     = (state_q != ST_IDLE);
    mem_data_o = rdata_q;
  end

  // Request source selection, error classification and lane mask.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_we   = mem_we_i;
      src_addr = mem_addr_i;
      src_sel  = mem_sel_i;
      src_data = mem_data_i;
    end else begin
      src_we   = req_we_q;
      src_addr = req_addr_q;
      src_sel  = req_sel_q;
      src_data = req_data_q;
    end
    src_idx   = src_addr[ADDR_W+1:2];
    src_err   = (src_addr[1:0] != 2'b00) ||
                ((src_addr >> (ADDR_W + 2)) != 32'd0) ||
                (src_sel == 4'b0000);
    lane_mask = {{8{src_sel[3]}}, {8{src_sel[2]}}, {8{src_sel[1]}}, {8{src_sel[0]}}};
  end

  // Counter and response datapath: loaded on accept, evaluated on RESP entry.
  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rd_word = mem_q[src_idx];
    if (accept) begin
      cnt_d = WAIT_LD;
    end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (enter_resp) begin
      err_d = src_err;
      // Lane-masked raw word; sign/zero extension belongs to the load/store stage.
      if (src_err || src_we) begin
        rdata_d = 32'd0;
      end else begin
        rdata_d = rd_word & lane_mask;
      end
    end else if (state_q == ST_RESP) begin
      // Leaving RESP: drop the read data so it is only visible with ack_o.
      err_d   = 1'b0;
      rdata_d = 32'd0;
    end
    // Writes only commit on a clean RESP entry and never while reset is asserted.
    mem_wr_en = enter_resp && src_we && !src_err && rst;
  end

  // Byte-lane write port; array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (src_sel[i]) begin
          mem_q[src_idx][8*i +: 8] <= src_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Data-memory responder on the far side of the load/store stage's memory port.
- Accepts one request at a time over the ce/we/addr/sel/data bus and performs byte-lane-masked writes or reads on an internal word array.
- Adds a programmable number of wait states; signals completion with a one-cycle ack and flags illegal accesses.
- Replaces the ideal combinational RAM so stall handling can be exercised.

Parameters:
- ADDR_W, 10: word-address width; depth = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 1: extra cycles between request accept and completion (legal range 0..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_ce_i  input  1  request valid; held high by the requester until ack_o.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_addr_i  input  32  byte address.
- mem_sel_i  input  4  byte-lane enables; bit i maps to data bits [8i+7:8i] (little-endian lanes).
- mem_data_i  input  32  write data.
- mem_data_o  output  32  read data; valid only while ack_o = 1.
- ack_o  output  1  one-cycle completion strobe.
- err_o  output  1  one-cycle error strobe, coincident with ack_o.
- busy_o  output  1  high from accept until the ack cycle ends.

Behaviour:
- Reset:
  - rst = 0 forces state IDLE immediately, regardless of clk.
  - mem_data_o = 0, ack_o = 0, err_o = 0, busy_o = 0, wait counter = 0.
  - Array contents are not reset.
  - Reset mid-operation aborts the request; no write is committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with mem_ce_i = 1, capture we, addr, sel and data into request registers.
  - Load counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, else to RESP.
  - busy_o rises after that edge.
- WAIT:
  - Decrement counter each edge.
  - On the edge where counter = 1, go to RESP.
  - Inputs are ignored; the captured request is used.
- Entry edge into RESP performs the access:
  - Write: for each sel bit set, array[addr[ADDR_W+1:2]] byte i <= data byte i; unselected bytes unchanged.
  - Read: mem_data_o byte i <= array byte i if sel[i], else 0. Sign/zero extension stays in the load/store stage.
- RESP:
  - ack_o = 1 for exactly this one cycle; mem_data_o holds read data.
  - For writes, mem_data_o = 0 in RESP.
  - Next edge returns to IDLE unconditionally; ack_o and busy_o clear.
  - mem_ce_i is not sampled in RESP.
- Latency: ack_o is high in cycle (accept edge + WAIT_CYCLES + 1). The WAIT_CYCLES = 0 case gives ack in the cycle after accept.
- Back-to-back requests: the next request is accepted at the earliest on the IDLE edge after RESP. A requester keeping mem_ce_i high through RESP starts a new request of the same type. The requester must drop mem_ce_i in the ack cycle unless it intends a repeat.
- Error conditions, evaluated on the captured request:
  - mem_addr_i[1:0] != 0;
  - mem_addr_i[31:ADDR_W+2] != 0;
  - mem_sel_i == 0.
- On error:
  - Still traverse WAIT/RESP with the same latency.
  - err_o = 1 together with ack_o.
  - No array write; mem_data_o = 0.
- Read-after-write to the same word: the write commits on its RESP-entry edge, so a following read returns the new data.
- Array is inferred as a plain register array, single port (one access per request).

Test Plan:
- Reset then idle: rst low 3 cycles, then high, mem_ce_i = 0 -> ack_o, err_o and busy_o stay 0; mem_data_o = 0.
- Write full word, then read back (WAIT_CYCLES = 1):
  - Write addr 0x00000010, sel 1111, data 0xDEADBEEF -> ack_o 2 cycles after accept, err_o = 0.
  - Read same address, sel 1111 -> mem_data_o = 0xDEADBEEF with ack_o.
- Byte-lane write:
  - Over 0xDEADBEEF at 0x10, write sel 0010, data 0x0000AA00.
  - Read sel 1111 -> 0xDEADAAEF.
  - Read sel 1100 -> 0xDEAD0000.
- Errors:
  - Write at 0x00000012 -> ack_o with err_o = 1; word at 0x10 unchanged.
  - Read at 0x00001000 (ADDR_W = 10) -> err_o = 1, mem_data_o = 0.
  - sel 0000 -> err_o = 1.
- Latency sweep, WAIT_CYCLES = 0 and 3:
  - ack_o appears exactly 1 and 4 cycles after the accept edge respectively.
  - busy_o is high for 1 and 4 cycles respectively.
  - mem_ce_i held high through RESP -> second ack exactly 1 idle cycle later.
- Reset mid-write: WAIT_CYCLES = 3, write 0x12345678 to 0x20, pulse rst low during WAIT -> no ack_o; subsequent read of 0x20 returns the prior contents.
